jtframe_sdram_bist: RTL and testbench
=====================================

# jtframe_sdram_bist

Parametrised SDRAM built-in self-test that sits between the game/test core and the multi-bank SDRAM controller. It generates its own data patterns instead of replaying a downloaded file, so it needs no ioctl port. It writes a configurable span in every bank, then reads it back and compares. It reports per-bank failure flags, a saturating error count, the first failing location and a watchdog timeout.

## Interface
Parameters:
- AW, 22, word address width per bank
- BANKS, 4, number of SDRAM banks tested (1..4); BW = max(1, clog2(BANKS))
- DW, 16, data width; 16 or 32 only; mask width MW = DW/8
- ERRW, 16, error counter width
- SEED, 32'hACE1_2468, LFSR seed (must be non-zero)
- TOUT, 1023, watchdog limit in cycles waiting for ack or rdy

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; ignored while busy
- mode  in  2  0 addr-as-data, 1 LFSR, 2 inverted addr, 3 checkerboard
- last_addr  in  AW  last word address tested in each bank (inclusive)
- rfsh_on  in  1  refresh enable while busy
- busy  out  1  test running
- done  out  1  one-cycle pulse at end of test or abort
- pass  out  1  high after a completed test with zero errors and no timeout
- timeout  out  1  watchdog fired on the last test
- ba_bad  out  BANKS  per-bank miscompare flag
- err_cnt  out  ERRW  saturating miscompare count
- first_err_addr  out  AW  address of first miscompare
- first_err_ba  out  BW  bank of first miscompare
- ba_addr  out  AW  shared request address
- ba_rd  out  BANKS  read request, one-hot on the current bank
- ba_wr  out  BANKS  write request, one-hot on the current bank
- ba_din  out  DW  write data
- ba_din_m  out  MW  write mask, active low, always 0
- ba_ack  in  BANKS  controller accepted the request
- ba_rdy  in  BANKS  write completed, or read data valid on data_read
- data_read  in  DW  read data
- refresh_en  out  1  1 when idle, rfsh_on when busy

## Operation
- FSM: IDLE -> WR_REQ -> WR_WAIT -> (next word) ... -> RD_REQ -> RD_WAIT -> CMP -> (next word) ... -> DONE -> IDLE.
- On start in IDLE, the block latches mode and last_addr and clears ba_bad, err_cnt, first_err_*, timeout and pass.
  - It also sets bank=0, addr=0, lfsr=SEED and busy=1.
- Write phase walks bank 0..BANKS-1 and, inside each bank, addr 0..last_addr.
- WR_REQ: ba_wr[bank] is held high until ba_ack[bank]. WR_WAIT then waits for ba_rdy[bank], and the block advances to the next word.
- After the last word of the last bank, it reloads lfsr=SEED, bank=0, addr=0 and enters the read phase.
- RD_REQ: ba_rd[bank] is held until ba_ack[bank]. RD_WAIT latches data_read on ba_rdy[bank]. CMP compares the latched word against the expected pattern.
- Pattern for word (bank, addr):
  - mode 0: {bank, addr}, zero-extended or truncated to DW.
  - mode 1: lfsr[DW-1:0], where lfsr is a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1, stepped once per word.
  - mode 2: the bitwise inverse of mode 0.
  - mode 3: all 5s when addr[0]=0, all As when addr[0]=1.
- Miscompare handling:
  - set ba_bad[bank];
  - increment err_cnt, saturating at all-ones;
  - on the first error only, capture first_err_addr and first_err_ba.
- Watchdog: a counter clears on entry to each REQ or WAIT state. When it reaches TOUT, the block sets timeout, drops all requests and goes to DONE.
- DONE: pulses done for one cycle, sets pass = (err_cnt==0 && !timeout), clears busy and returns to IDLE.
- ba_addr holds addr throughout a request. At most one bit of ba_rd|ba_wr is high at any time.
- last_addr=0 tests exactly one word per bank. Address wrap at all-ones AW is never reached because the compare is on last_addr.

## Timing
- Reset values: busy=0, done=0, pass=0, timeout=0, ba_bad=0, err_cnt=0, first_err_*=0, ba_rd=0, ba_wr=0, ba_addr=0, ba_din=0, ba_din_m=0, refresh_en=1.
- An asserted rst mid-test drops requests asynchronously. No done pulse is produced.
- start is sampled on the clock edge, and busy rises the next cycle. The first request is asserted on the same cycle busy rises.
- The request deasserts on the cycle after ba_ack is sampled high.
- With ack and rdy returned with zero delay, each word takes 3 cycles to write and 4 cycles to read. Total = 7·BANKS·(last_addr+1) + 2 cycles.
- ba_ack or ba_rdy arriving on a non-selected bank is ignored.
- ba_ack and ba_rdy may arrive in the same cycle; this is treated as ack followed by immediate rdy.
- done and busy fall together. pass, timeout and the error outputs are stable from done until the next start.

## Test plan
- Mode 0, BANKS=4, last_addr=15, ideal memory model -> 64 writes with ba_din={bank,addr}, 64 reads, then done with pass=1, err_cnt=0, ba_bad=0000.
- Mode 1, model flips bit 3 on bank 2, addr 5 -> ba_bad=0100, err_cnt=1, first_err_ba=2, first_err_addr=5, pass=0.
- Mode 3, model stuck at 16'h5555 on bank 1 -> every odd addr fails, err_cnt=(last_addr+1)/2, ba_bad=0010.
- ba_ack withheld on bank 3 for TOUT+5 cycles -> timeout=1, requests drop, done pulses exactly once, pass=0.
- rst asserted during RD_WAIT -> all outputs take their reset values immediately. A new start then runs a clean pass=1 test.
- ERRW=4, every word corrupted, last_addr=31 -> err_cnt saturates at 15. start pulses while busy are ignored.

Source files
------------

// File: rtl/jtframe_sdram_bist_if.sv
// SDRAM controller bus as seen by the BIST.
//   master : BIST side. Drives address, one-hot rd/wr requests, write data and mask,
//            and refresh enable. Receives ack, rdy and read data.
//   slave  : controller side, with the directions mirrored.
interface jtframe_sdram_bist_if #(
  parameter int AW    = 22,
  parameter int BANKS = 4,
  parameter int DW    = 16
);
  localparam int MW = DW/8;

  logic [AW-1:0]    ba_addr;
  logic [BANKS-1:0] ba_rd;
  logic [BANKS-1:0] ba_wr;
  logic [DW-1:0]    ba_din;
  logic [MW-1:0]    ba_din_m;
  logic [BANKS-1:0] ba_ack;
  logic [BANKS-1:0] ba_rdy;
  logic [DW-1:0]    data_read;
  logic             refresh_en;

  modport master (
    output ba_addr, ba_rd, ba_wr, ba_din, ba_din_m, refresh_en,
    input  ba_ack, ba_rdy, data_read
  );

  modport slave (
    input  ba_addr, ba_rd, ba_wr, ba_din, ba_din_m, refresh_en,
    output ba_ack, ba_rdy, data_read
  );
endinterface

// File: rtl/jtframe_sdram_bist.sv
// SDRAM built-in self-test.
// The block writes a generated pattern to words 0..last_addr of every bank, then reads
// each word back and compares it with the same pattern.
//   clk, rst        : clock and asynchronous active-high reset
//   start           : one-cycle start pulse. It is ignored while busy.
//   mode            : 0 {bank,addr}, 1 LFSR, 2 ~{bank,addr}, 3 checkerboard
//   last_addr       : last word tested in each bank (inclusive)
//   rfsh_on         : refresh enable passed through while busy
//   busy/done/pass/timeout : test status. done is a one-cycle pulse.
//   ba_bad, err_cnt, first_err_addr, first_err_ba : error report
//   bus             : controller bus (address, requests, data, ack/rdy, refresh_en)
module jtframe_sdram_bist #(
  parameter int          AW    = 22,
  parameter int          BANKS = 4,
  parameter int          DW    = 16,
  parameter int          ERRW  = 16,
  parameter logic [31:0] SEED  = 32'hACE1_2468,
  parameter int          TOUT  = 1023,
  localparam int         BW    = (BANKS > 1) ? $clog2(BANKS) : 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    last_addr,
  input  logic             rfsh_on,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [BANKS-1:0] ba_bad,
  output logic [ERRW-1:0]  err_cnt,
  output logic [AW-1:0]    first_err_addr,
  output logic [BW-1:0]    first_err_ba,
  jtframe_sdram_bist_if.master bus
);
  localparam int TW = $clog2(TOUT+1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_WR_NEXT,
    S_RD_REQ, S_RD_WAIT, S_CMP, S_RD_NEXT, S_DONE
  } state_t;

  state_t           r_state, w_nxt;
  logic [1:0]       r_mode;
  logic [AW-1:0]    r_last, r_addr;
  logic [BW-1:0]    r_bank;
  logic [31:0]      r_lfsr, w_lfsr_nxt;
  logic [DW-1:0]    r_rdata, w_pat;
  logic [TW-1:0]    r_wdog;
  logic             r_busy, r_pass, r_tout;
  logic [BANKS-1:0] r_bad, w_sel;
  logic [ERRW-1:0]  r_err;
  logic [AW-1:0]    r_ferr_a;
  logic [BW-1:0]    r_ferr_b;
  logic             w_ack, w_rdy, w_last, w_wd_hit, w_tout, w_rd_cap;

  // Only the currently selected bank's handshake counts.
  assign w_sel    = BANKS'(1) << r_bank;
  assign w_ack    = |(bus.ba_ack & w_sel);
  assign w_rdy    = |(bus.ba_rdy & w_sel);
  assign w_last   = (r_addr == r_last) && (r_bank == BW'(BANKS-1));
  assign w_wd_hit = (r_wdog == TW'(TOUT));

  // Galois form of x^32+x^22+x^2+x+1 (right shift, taps on bits 31,21,1,0).
  assign w_lfsr_nxt = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);

  always_comb begin
    w_pat = DW'({r_bank, r_addr});
    case (r_mode)
      2'd0: w_pat = DW'({r_bank, r_addr});
      2'd1: w_pat = r_lfsr[DW-1:0];
      2'd2: w_pat = ~DW'({r_bank, r_addr});
      2'd3: w_pat = r_addr[0] ? {(DW/2){2'b10}} : {(DW/2){2'b01}};
      default: ;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt    = r_state;
    w_tout   = 1'b0;
    w_rd_cap = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_nxt = S_WR_REQ;
      // ack and rdy in the same cycle skip the wait state.
      S_WR_REQ:  if (w_ack) w_nxt = w_rdy ? S_WR_NEXT : S_WR_WAIT;
                 else if (w_wd_hit) begin w_nxt = S_DONE; w_tout = 1'b1; end
      S_WR_WAIT: if (w_rdy) w_nxt = S_WR_NEXT;
                 else if (w_wd_hit) begin w_nxt = S_DONE; w_tout = 1'b1; end
      S_WR_NEXT: w_nxt = w_last ? S_RD_REQ : S_WR_REQ;
      S_RD_REQ:  if (w_ack) begin
                   w_nxt    = w_rdy ? S_CMP : S_RD_WAIT;
                   w_rd_cap = w_rdy;
                 end else if (w_wd_hit) begin w_nxt = S_DONE; w_tout = 1'b1; end
      S_RD_WAIT: if (w_rdy) begin w_nxt = S_CMP; w_rd_cap = 1'b1; end
                 else if (w_wd_hit) begin w_nxt = S_DONE; w_tout = 1'b1; end
      S_CMP:     w_nxt = S_RD_NEXT;
      S_RD_NEXT: w_nxt = w_last ? S_DONE : S_RD_REQ;
      S_DONE:    w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= '0;
      r_last   <= '0;
      r_addr   <= '0;
      r_bank   <= '0;
      r_lfsr   <= SEED;
      r_rdata  <= '0;
      r_wdog   <= '0;
      r_busy   <= 1'b0;
      r_pass   <= 1'b0;
      r_tout   <= 1'b0;
      r_bad    <= '0;
      r_err    <= '0;
      r_ferr_a <= '0;
      r_ferr_b <= '0;
    end else begin
      // The watchdog restarts whenever the state changes, so every REQ/WAIT entry gets
      // a full TOUT budget.
      if (w_nxt != r_state)  r_wdog <= '0;
      else if (!w_wd_hit)    r_wdog <= r_wdog + 1'b1;

      if (r_state == S_IDLE && start) begin
        r_mode   <= mode;
        r_last   <= last_addr;
        r_bank   <= '0;
        r_addr   <= '0;
        r_lfsr   <= SEED;
        r_busy   <= 1'b1;
        r_bad    <= '0;
        r_err    <= '0;
        r_ferr_a <= '0;
        r_ferr_b <= '0;
        r_tout   <= 1'b0;
        r_pass   <= 1'b0;
      end

      if (w_rd_cap) r_rdata <= bus.data_read;

      if (r_state == S_CMP && r_rdata != w_pat) begin
        r_bad[r_bank] <= 1'b1;
        if (r_err == '0) begin
          r_ferr_a <= r_addr;
          r_ferr_b <= r_bank;
        end
        if (r_err != '1) r_err <= r_err + 1'b1;
      end

      // Advance to the next word. After the last word, rewind so that the read phase
      // regenerates the same sequence.
      if (r_state == S_WR_NEXT || r_state == S_RD_NEXT) begin
        if (w_last) begin
          r_lfsr <= SEED;
          r_bank <= '0;
          r_addr <= '0;
        end else begin
          r_lfsr <= w_lfsr_nxt;
          if (r_addr == r_last) begin
            r_addr <= '0;
            r_bank <= r_bank + 1'b1;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
      end

      // The result is registered on entry to DONE, so it is already valid during the
      // done pulse. err_cnt is final by then because CMP precedes RD_NEXT.
      if (w_nxt == S_DONE && r_state != S_DONE) begin
        r_tout <= w_tout;
        r_pass <= !w_tout && (r_err == '0);
      end

      if (r_state == S_DONE) r_busy <= 1'b0;
    end
  end

  // ---------------- outputs ----------------
  assign busy           = r_busy;
  assign done           = (r_state == S_DONE);
  assign pass           = r_pass;
  assign timeout        = r_tout;
  assign ba_bad         = r_bad;
  assign err_cnt        = r_err;
  assign first_err_addr = r_ferr_a;
  assign first_err_ba   = r_ferr_b;

  // Requests are decoded from the state register, so an asynchronous reset drops them
  // immediately.
  assign bus.ba_addr    = r_addr;
  assign bus.ba_wr      = (r_state == S_WR_REQ) ? w_sel : '0;
  assign bus.ba_rd      = (r_state == S_RD_REQ) ? w_sel : '0;
  assign bus.ba_din     = (r_state == S_WR_REQ || r_state == S_WR_WAIT) ? w_pat : '0;
  assign bus.ba_din_m   = '0;
  assign bus.refresh_en = r_busy ? rfsh_on : 1'b1;
endmodule

// File: tb/tb_jtframe_sdram_bist.sv
module tb_jtframe_sdram_bist;
  localparam int          AW    = 8;
  localparam int          BANKS = 4;
  localparam int          DW    = 16;
  localparam int          ERRW  = 4;
  localparam int          TOUT  = 100;
  localparam logic [31:0] SEED  = 32'hACE1_2468;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, rfsh_on = 1'b0;
  logic [1:0]       mode = '0;
  logic [AW-1:0]    last_addr = '0;
  logic             busy, done, pass, timeout;
  logic [BANKS-1:0] ba_bad;
  logic [ERRW-1:0]  err_cnt;
  logic [AW-1:0]    first_err_addr;
  logic [1:0]       first_err_ba;

  int checks = 0, failures = 0;

  jtframe_sdram_bist_if #(.AW(AW), .BANKS(BANKS), .DW(DW)) bif();

  jtframe_sdram_bist #(.AW(AW), .BANKS(BANKS), .DW(DW), .ERRW(ERRW), .SEED(SEED), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .last_addr(last_addr), .rfsh_on(rfsh_on),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .ba_bad(ba_bad),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr), .first_err_ba(first_err_ba),
    .bus(bif.master)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [DW-1:0]    mem [0:BANKS-1][0:(1<<AW)-1];
  logic [BANKS-1:0] hold_ack = '0;
  logic             hold_rdy = 1'b0;
  int               corr = 0;
  int               n_wr = 0, n_rd = 0;

  // Zero-delay ack. rdy and read data follow on the next cycle.
  assign bif.ba_ack = (bif.ba_wr | bif.ba_rd) & ~hold_ack;

  function automatic logic [DW-1:0] rd_val(int b, int a, logic [DW-1:0] v);
    case (corr)
      1: if (b == 2 && a == 5) return v ^ 16'h0008;
      2: if (b == 1) return 16'h5555;
      3: return v ^ 16'h0001;
      default: ;
    endcase
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bif.ba_rdy    <= '0;
      bif.data_read <= '0;
    end else begin
      bif.ba_rdy <= '0;
      for (int b = 0; b < BANKS; b++) begin
        if (bif.ba_ack[b] && bif.ba_wr[b]) begin
          mem[b][bif.ba_addr] = bif.ba_din;
          n_wr++;
          bif.ba_rdy[b] <= 1'b1;
        end
        if (bif.ba_ack[b] && bif.ba_rd[b]) begin
          bif.data_read <= rd_val(b, int'(bif.ba_addr), mem[b][bif.ba_addr]);
          n_rd++;
          if (!hold_rdy) bif.ba_rdy[b] <= 1'b1;
        end
      end
    end
  end

  // Galois LFSR for x^32+x^22+x^2+x+1, shifting right.
  function automatic logic [31:0] lstep(logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Counts words whose stored contents differ from the expected pattern.
  function automatic int mem_bad(logic [1:0] m, int la);
    logic [31:0]   l = SEED;
    logic [DW-1:0] e;
    logic [1:0]    bb;
    logic [7:0]    aa;
    int            n = 0;
    for (int b = 0; b < BANKS; b++)
      for (int a = 0; a <= la; a++) begin
        bb = 2'(b); aa = 8'(a);
        case (m)
          2'd0: e = {6'd0, bb, aa};
          2'd1: e = l[15:0];
          2'd2: e = ~{6'd0, bb, aa};
          default: e = aa[0] ? 16'hAAAA : 16'h5555;
        endcase
        if (mem[b][a] !== e) n++;
        l = lstep(l);
      end
    return n;
  endfunction

  // ---------------- run helper (no comparisons) ----------------
  logic       s_busy, s_rf;
  logic [3:0] s_wr;
  logic [7:0] s_addr;
  logic [15:0] s_din;

  // Cycle c counts clock edges after the edge that sampled start. The first c with
  // done high is dcyc, and the first c with busy low is bfall. Both stay -1 if the
  // event does not happen within the limit.
  task automatic run(input logic [1:0] m, input logic [7:0] la, input int limit,
                     input int sp, output int dcyc, output int bfall, output int ndone);
    mode = m; last_addr = la; n_wr = 0; n_rd = 0;
    dcyc = -1; bfall = -1; ndone = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_busy = busy; s_wr = bif.ba_wr; s_addr = bif.ba_addr; s_rf = bif.refresh_en; s_din = bif.ba_din;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      start = (sp > 0 && (c == sp || c == sp + 200));
      if (done) begin ndone++; if (dcyc < 0) dcyc = c; end
      if (!busy && bfall < 0) bfall = c;
      if (bfall >= 0 && c >= bfall + 2) break;
    end
    start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, pass, timeout, ba_bad, err_cnt, first_err_addr, first_err_ba} !== '0) begin
      failures++; $display("FAIL reset_status got %b expected 0",
        {busy, done, pass, timeout, ba_bad, err_cnt, first_err_addr, first_err_ba});
    end
    checks++;
    if ({bif.ba_rd, bif.ba_wr, bif.ba_addr, bif.ba_din, bif.ba_din_m} !== '0) begin
      failures++; $display("FAIL reset_bus got %h expected 0",
        {bif.ba_rd, bif.ba_wr, bif.ba_addr, bif.ba_din, bif.ba_din_m});
    end
    checks++;
    if (bif.refresh_en !== 1'b1) begin
      failures++; $display("FAIL reset_refresh_en got %b expected 1", bif.refresh_en);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0;
    int dc, bf, nd;
    for (int b = 0; b < BANKS; b++) for (int a = 0; a < 256; a++) mem[b][a] = 16'hDEAD;
    corr = 0; rfsh_on = 1'b0;
    run(2'd0, 8'd15, 2000, 0, dc, bf, nd);
    checks++;
    if (s_busy !== 1'b1 || s_wr !== 4'b0001 || s_addr !== 8'd0 || s_din !== 16'h0000) begin
      failures++; $display("FAIL m0_first_cycle got busy=%b wr=%b addr=%0d din=%h expected 1 0001 0 0000",
        s_busy, s_wr, s_addr, s_din);
    end
    checks++;
    if (s_rf !== 1'b0) begin failures++; $display("FAIL m0_refresh_busy got %b expected 0", s_rf); end
    // 64 words: done on cycle 7*64 and busy low one cycle later, so start cycle plus
    // busy cycles total 7*64+2.
    checks++;
    if (dc != 448 || bf != 449 || nd != 1) begin
      failures++; $display("FAIL m0_timing got done@%0d busyfall@%0d pulses=%0d expected 448 449 1", dc, bf, nd);
    end
    checks++;
    if (n_wr != 64 || n_rd != 64) begin
      failures++; $display("FAIL m0_counts got wr=%0d rd=%0d expected 64 64", n_wr, n_rd);
    end
    checks++;
    if (mem_bad(2'd0, 15) != 0) begin
      failures++; $display("FAIL m0_mem_data got %0d bad words expected 0", mem_bad(2'd0, 15));
    end
    checks++;
    if (pass !== 1'b1 || err_cnt !== 4'd0 || ba_bad !== 4'b0000 || timeout !== 1'b0) begin
      failures++; $display("FAIL m0_result got pass=%b err=%0d bad=%b to=%b expected 1 0 0000 0",
        pass, err_cnt, ba_bad, timeout);
    end
    checks++;
    if (bif.refresh_en !== 1'b1) begin
      failures++; $display("FAIL m0_refresh_idle got %b expected 1", bif.refresh_en);
    end
  endtask

  task automatic test_lfsr_flip;
    int dc, bf, nd;
    corr = 1;
    run(2'd1, 8'd15, 2000, 0, dc, bf, nd);
    checks++;
    if (mem_bad(2'd1, 15) != 0) begin
      failures++; $display("FAIL lfsr_mem_data got %0d bad words expected 0", mem_bad(2'd1, 15));
    end
    checks++;
    if (ba_bad !== 4'b0100 || err_cnt !== 4'd1) begin
      failures++; $display("FAIL lfsr_errs got bad=%b err=%0d expected 0100 1", ba_bad, err_cnt);
    end
    checks++;
    if (first_err_ba !== 2'd2 || first_err_addr !== 8'd5) begin
      failures++; $display("FAIL lfsr_first got ba=%0d addr=%0d expected 2 5", first_err_ba, first_err_addr);
    end
    checks++;
    if (pass !== 1'b0 || dc != 448) begin
      failures++; $display("FAIL lfsr_pass got pass=%b done@%0d expected 0 448", pass, dc);
    end
  endtask

  task automatic test_checker_stuck;
    int dc, bf, nd;
    corr = 2;
    run(2'd3, 8'd15, 2000, 0, dc, bf, nd);
    checks++;
    if (mem_bad(2'd3, 15) != 0) begin
      failures++; $display("FAIL chk_mem_data got %0d bad words expected 0", mem_bad(2'd3, 15));
    end
    checks++;
    if (err_cnt !== 4'd8 || ba_bad !== 4'b0010) begin
      failures++; $display("FAIL chk_errs got err=%0d bad=%b expected 8 0010", err_cnt, ba_bad);
    end
    checks++;
    if (first_err_ba !== 2'd1 || first_err_addr !== 8'd1 || pass !== 1'b0) begin
      failures++; $display("FAIL chk_first got ba=%0d addr=%0d pass=%b expected 1 1 0",
        first_err_ba, first_err_addr, pass);
    end
  endtask

  task automatic test_timeout;
    int dc, bf, nd;
    corr = 0; hold_ack = 4'b1000;
    // 12 words (36 cycles) reach bank 3. Its WR_REQ then lasts TOUT+1 cycles, so done
    // comes on cycle 36+TOUT+1.
    run(2'd0, 8'd3, TOUT + 200, 0, dc, bf, nd);
    checks++;
    if (dc != 36 + TOUT + 1 || nd != 1) begin
      failures++; $display("FAIL tout_done got done@%0d pulses=%0d expected %0d 1", dc, nd, 36 + TOUT + 1);
    end
    checks++;
    if (timeout !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL tout_status got to=%b pass=%b busy=%b expected 1 0 0", timeout, pass, busy);
    end
    checks++;
    if ((bif.ba_wr | bif.ba_rd) !== 4'b0000) begin
      failures++; $display("FAIL tout_req_drop got %b expected 0000", bif.ba_wr | bif.ba_rd);
    end
    hold_ack = '0;
  endtask

  task automatic test_rst_midtest;
    int dc, bf, nd;
    bit found = 0;
    corr = 0; mode = 2'd2; last_addr = 8'd3;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      if (bif.ba_rd === 4'b0010 && bif.ba_addr === 8'd2) found = 1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL rst_reach_read got no bank1 addr2 read expected one");
    end else begin
      hold_rdy = 1'b1;
      @(posedge clk); #3 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, bif.ba_rd, bif.ba_wr, bif.ba_addr, bif.ba_din} !== '0 || bif.refresh_en !== 1'b1) begin
        failures++; $display("FAIL rst_async got busy=%b done=%b rd=%b wr=%b addr=%0d rf=%b expected 0 0 0 0 0 1",
          busy, done, bif.ba_rd, bif.ba_wr, bif.ba_addr, bif.refresh_en);
      end
      nd = 0;
      repeat (3) begin @(posedge clk); #1; if (done) nd++; end
      @(negedge clk) rst = 1'b0; hold_rdy = 1'b0;
      repeat (2) begin @(posedge clk); #1; if (done) nd++; end
      checks++;
      if (nd != 0) begin failures++; $display("FAIL rst_no_done got %0d pulses expected 0", nd); end
    end
    run(2'd2, 8'd3, 500, 0, dc, bf, nd);
    checks++;
    if (pass !== 1'b1 || err_cnt !== 4'd0 || timeout !== 1'b0 || dc != 112) begin
      failures++; $display("FAIL rst_rerun got pass=%b err=%0d to=%b done@%0d expected 1 0 0 112",
        pass, err_cnt, timeout, dc);
    end
    checks++;
    if (mem_bad(2'd2, 3) != 0) begin
      failures++; $display("FAIL rst_rerun_mem got %0d bad words expected 0", mem_bad(2'd2, 3));
    end
  endtask

  task automatic test_saturate;
    int dc, bf, nd;
    corr = 3;
    // 128 words. Extra start pulses on cycles 50 and 250 must not restart the test.
    run(2'd2, 8'd31, 2000, 50, dc, bf, nd);
    checks++;
    if (dc != 896 || bf != 897 || nd != 1) begin
      failures++; $display("FAIL sat_timing got done@%0d busyfall@%0d pulses=%0d expected 896 897 1", dc, bf, nd);
    end
    checks++;
    if (err_cnt !== 4'd15 || ba_bad !== 4'b1111) begin
      failures++; $display("FAIL sat_errs got err=%0d bad=%b expected 15 1111", err_cnt, ba_bad);
    end
    checks++;
    if (first_err_ba !== 2'd0 || first_err_addr !== 8'd0 || pass !== 1'b0) begin
      failures++; $display("FAIL sat_first got ba=%0d addr=%0d pass=%b expected 0 0 0",
        first_err_ba, first_err_addr, pass);
    end
    corr = 0;
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_lfsr_flip();
    test_checker_stuck();
    test_timeout();
    test_rst_midtest();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
